prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-serial program loader that sits directly upstream of Top_Module_Pipe.
- Drives the core's instruction-memory write port (we0, wr_addr0, wr_din0) and its resetpc run-release.
- Receives a framed byte stream: a 2-byte little-endian word count N, then N words of 4 bytes each, little-endian.
- Writes each word to consecutive word addresses starting at byte address 0, then asserts resetpc so the core starts fetching.

Parameters:
- ADDR_W, 9: byte-address width of the imem write port.
- MAX_WORDS, 128: imem capacity in words; must satisfy MAX_WORDS*4 <= 2**ADDR_W.
- CNT_W, 8: width of words_loaded; must satisfy 2**CNT_W > MAX_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- we0  out  1  imem write enable.
- wr_addr0  out  ADDR_W  imem byte address; always a multiple of 4.
- wr_din0  out  32  imem write data.
- resetpc  out  1  core run-release: 0 holds the PC in reset, 1 lets it run.
- busy  out  1  a load is in progress.
- err  out  1  header count exceeded MAX_WORDS.
- words_loaded  out  CNT_W  number of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are registered and reset to 0: we0, wr_addr0, wr_din0, resetpc, busy, err, rx_ready, words_loaded.
- Byte transfer occurs on a rising edge with rx_valid && rx_ready. rx_data is ignored at any other time.
- rx_ready is registered and high only in HDR0, HDR1 and BYTE. It deasserts on the same edge that accepts the last byte of a field.
- FSM states: IDLE, HDR0, HDR1, BYTE, WRITE, DONE, ERR.
- IDLE: start=1 -> HDR0. Same edge: busy<=1, err<=0, resetpc<=0, words_loaded<=0, byte index<=0.
- HDR0: accepted byte -> N[7:0]; go to HDR1.
- HDR1: accepted byte -> N[15:8]. Then:
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERR.
  - otherwise -> BYTE.
- BYTE: each accepted byte k (0..3) fills word bits [8k+7:8k]. The 4th accepted byte -> WRITE.
- WRITE: exactly one cycle with we0=1, wr_addr0=4*words_loaded, wr_din0=assembled word. On exit, words_loaded increments.
  - If the incremented count equals N -> DONE.
  - Otherwise -> BYTE.
- Write latency: we0 is high in the cycle after the edge that accepts the 4th byte of a word.
- Minimum 5 cycles per word at full rate, because rx_ready is low during WRITE.
- we0 is never high outside WRITE. wr_addr0 and wr_din0 hold their last values otherwise.
- DONE: resetpc=1 from the first DONE cycle, busy=0. Held until start or reset.
- ERR: err=1, busy=0, resetpc=0. No memory writes occur. rx_ready=0, so no further stream bytes are consumed.
- start in DONE or ERR -> HDR0 (restart). resetpc and err drop on that edge.
- start while busy (HDR0..WRITE) is ignored. Loading continues undisturbed.
- Simultaneous start and rx_valid in IDLE: the byte is not consumed, because rx_ready is 0 in IDLE.
- Reset mid-load: returns to IDLE immediately, resetpc=0. Partially loaded memory contents are left as-is.
- Address wrap cannot occur, because N is bounded by MAX_WORDS.

Decomposition:
- Shared package prog_loader_pkg holds:
  - the state enum typedef (IDLE..ERR);
  - HDR_BYTES=2 and WORD_BYTES=4 constants;
  - the MAX_WORDS default, shared with the imem depth of the top module.
- One natural sub-module: byte_packer, a 4-byte little-endian shift/assemble register with a word_full flag. FSM and address counter stay in prog_loader.

Test Plan:
- Load 3 words at full rate: N=3 (bytes 03 00), words 0x00500093, 0x00A00113, 0x002081B3 -> three single-cycle we0 pulses at addr 0, 4, 8 with those data; resetpc=1 the cycle after the third WRITE; words_loaded=3.
- Gapped stream with rx_valid toggled every other cycle, N=1, word 0xDEADBEEF -> one write at addr 0 with data 0xDEADBEEF; no extra or early we0.
- Header N=0 -> no we0 ever; DONE reached; resetpc=1, busy=0, err=0.
- Header N=129 (bytes 81 00) -> err=1, resetpc=0, no writes, rx_ready stays 0; a following start pulse clears err and accepts a new header.
- Reset pulled low after 2 of 4 words -> all outputs 0 asynchronously; new start plus N=1 load writes addr 0, and words_loaded=1.
- start pulse in DONE -> resetpc falls next edge, busy=1; start asserted mid-load -> ignored, load completes with correct count.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the byte-serial program loader.
//               Holds the loader state encoding, the frame field sizes, and
//               the default instruction-memory capacity in words.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        BYTE  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    // Frame geometry: 2-byte LE word count, then 4-byte LE words
    localparam int HDR_BYTES     = 2;
    localparam int WORD_BYTES    = 4;

    // Default imem capacity in words, shared with the core's imem depth
    localparam int MAX_WORDS_DEF = 128;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_byte_packer
// Description : Little-endian 4-byte word assembler. Each load shifts the new
//               byte into the top of the holding register so the first byte
//               of a word ends up in bits [7:0].
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous active-low reset
//               clr       - restart assembly at byte 0
//               load      - accept byte_in this cycle
//               byte_in   - stream byte
//               word      - assembled word including byte_in as byte 3
//               word_full - this load supplies byte 3 (word complete)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    // Only the three earlier bytes need storage: the fourth is taken straight
    // from byte_in so the word is available on the edge that accepts it.
    logic [23:0] r_bytes;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bytes <= '0;
            r_cnt   <= '0;
        end else if (clr) begin
            r_cnt   <= '0;
        end else if (load) begin
            r_bytes <= {byte_in, r_bytes[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign word      = {byte_in, r_bytes};
    assign word_full = load && (r_cnt == 2'(WORD_BYTES - 1));

endmodule : prog_loader_byte_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-serial program loader feeding the core's imem write port.
//               Frame: 2-byte LE word count N, then N little-endian words.
//               Words go to byte addresses 0,4,8,...; resetpc is released
//               once all N words are written.
// Ports       : clk, reset (async active-low)
//               start            - pulse to begin/restart a load
//               rx_data/rx_valid - byte stream in; rx_ready - byte accepted
//               we0/wr_addr0/wr_din0 - imem write port
//               resetpc          - 1 lets the core run
//               busy / err       - load in progress / header count too large
//               words_loaded     - words written in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [31:0]       wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    state_t      r_state;
    logic [15:0] r_n;

    logic        w_accept;
    logic        w_restart;
    logic [15:0] w_hdr_n;
    logic [CNT_W-1:0] w_next_cnt;
    logic [31:0] w_word;
    logic        w_word_full;

    assign w_accept   = rx_valid && rx_ready;
    // start only matters when no load is running
    assign w_restart  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_hdr_n    = {rx_data, r_n[7:0]};
    assign w_next_cnt = words_loaded + 1'b1;

    prog_loader_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_restart),
        .load      (w_accept && (r_state == BYTE)),
        .byte_in   (rx_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_n          <= '0;
            rx_ready     <= 1'b0;
            we0          <= 1'b0;
            wr_addr0     <= '0;
            wr_din0      <= '0;
            resetpc      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            we0 <= 1'b0;
            if (w_restart) begin
                r_state      <= HDR0;
                rx_ready     <= 1'b1;
                busy         <= 1'b1;
                err          <= 1'b0;
                resetpc      <= 1'b0;
                words_loaded <= '0;
            end else begin
                case (r_state)
                    HDR0: begin
                        if (w_accept) begin
                            r_n[7:0] <= rx_data;
                            r_state  <= HDR1;
                        end
                    end
                    HDR1: begin
                        if (w_accept) begin
                            r_n <= w_hdr_n;
                            if (w_hdr_n == 16'd0) begin
                                r_state  <= DONE;
                                rx_ready <= 1'b0;
                                busy     <= 1'b0;
                                resetpc  <= 1'b1;
                            end else if (w_hdr_n > 16'(MAX_WORDS)) begin
                                r_state  <= ERR;
                                rx_ready <= 1'b0;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                r_state  <= BYTE;
                            end
                        end
                    end
                    BYTE: begin
                        // The write is issued on the edge accepting byte 3 so
                        // we0 lands in the very next cycle.
                        if (w_word_full) begin
                            r_state  <= WRITE;
                            rx_ready <= 1'b0;
                            we0      <= 1'b1;
                            wr_addr0 <= ADDR_W'(words_loaded) * ADDR_W'(WORD_BYTES);
                            wr_din0  <= w_word;
                        end
                    end
                    WRITE: begin
                        words_loaded <= w_next_cnt;
                        if (16'(w_next_cnt) == r_n) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                            resetpc <= 1'b1;
                        end else begin
                            r_state  <= BYTE;
                            rx_ready <= 1'b1;
                        end
                    end
                    IDLE, DONE, ERR: begin
                        // wait for start (handled above)
                    end
                    default: begin
                        r_state  <= IDLE;
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Expected imem writes are
//               queued as words are sent and compared when we0 pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W    = 9;
    localparam int MAX_WORDS = 128;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [31:0]       wr_din0;
    logic              resetpc;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  words_loaded;

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_writes = 0;
    logic prev_we0 = 1'b0;
    wr_t exp_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .we0          (we0),
        .wr_addr0     (wr_addr0),
        .wr_din0      (wr_din0),
        .resetpc      (resetpc),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (we0) begin
            wr_t e;
            check("we0_single_cycle", {31'd0, prev_we0}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_we0", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr0", {23'd0, wr_addr0}, {23'd0, e.addr});
                check("wr_din0", wr_din0, e.data);
            end
            n_writes++;
        end
        prev_we0 = we0;
    end

    // Called at a negedge; returns at the negedge after the byte was accepted
    // with rx_valid still high.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        exp_q.push_back('{addr: exp_addr, data: w});
        exp_addr = exp_addr + ADDR_W'(4);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * k);
            send_byte(tmp[7:0], gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_addr = '0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!resetpc && !err && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_we0", {31'd0, we0}, 0);
        check("rst_rx_ready", {31'd0, rx_ready}, 0);
        check("rst_resetpc", {31'd0, resetpc}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_words", {24'd0, words_loaded}, 0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- 3 words, full rate (start with rx_valid high) ----
        rx_valid = 1'b1; rx_data = 8'h03;
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 1);
        check("ready_after_start", {31'd0, rx_ready}, 1);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(32'h00500093, 0);
        send_word(32'h00A00113, 0);
        send_word(32'h002081B3, 0);
        rx_valid = 1'b0;
        check("write3_resetpc_low", {31'd0, resetpc}, 0);
        check("write3_we0", {31'd0, we0}, 1);
        @(negedge clk);
        check("load3_resetpc", {31'd0, resetpc}, 1);
        check("load3_busy", {31'd0, busy}, 0);
        check("load3_words", {24'd0, words_loaded}, 3);
        check("load3_writes", n_writes, 3);

        // ---------------- gapped stream, N=1 ----------------
        wr0 = n_writes;
        pulse_start();
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_word(32'hDEADBEEF, 1);
        wait_done("gap_timeout");
        repeat (2) @(negedge clk);
        check("gap_writes", n_writes - wr0, 1);
        check("gap_words", {24'd0, words_loaded}, 1);
        check("gap_resetpc", {31'd0, resetpc}, 1);

        // ---------------- N=0 ----------------
        wr0 = n_writes;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        check("n0_resetpc", {31'd0, resetpc}, 1);
        check("n0_busy", {31'd0, busy}, 0);
        check("n0_err", {31'd0, err}, 0);
        repeat (3) @(negedge clk);
        check("n0_writes", n_writes - wr0, 0);

        // ---------------- N=129 -> ERR ----------------
        wr0 = n_writes;
        pulse_start();
        send_byte(8'h81, 0);
        send_byte(8'h00, 0);
        check("err_flag", {31'd0, err}, 1);
        check("err_resetpc", {31'd0, resetpc}, 0);
        check("err_busy", {31'd0, busy}, 0);
        rx_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            check("err_rx_ready", {31'd0, rx_ready}, 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("err_writes", n_writes - wr0, 0);
        pulse_start();
        check("err_cleared", {31'd0, err}, 0);
        check("err_restart_ready", {31'd0, rx_ready}, 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0);
        rx_valid = 1'b0;
        wait_done("err_reload_timeout");
        check("err_reload_words", {24'd0, words_loaded}, 1);

        // ---------------- reset mid-load ----------------
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_word(32'hA5A5A5A5, 0);
        send_word(32'h5A5A5A5A, 0);
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_we0", {31'd0, we0}, 0);
        check("mid_rst_addr", {23'd0, wr_addr0}, 0);
        check("mid_rst_din", wr_din0, 0);
        check("mid_rst_words", {24'd0, words_loaded}, 0);
        check("mid_rst_ready", {31'd0, rx_ready}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        rx_valid = 1'b0;
        wait_done("post_rst_timeout");
        check("post_rst_words", {24'd0, words_loaded}, 1);

        // ---------------- start in DONE, start mid-load ----------------
        pulse_start();
        check("restart_resetpc", {31'd0, resetpc}, 0);
        check("restart_busy", {31'd0, busy}, 1);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        exp_q.push_back('{addr: 9'd0, data: 32'h01020304});
        exp_q.push_back('{addr: 9'd4, data: 32'h0A0B0C0D});
        send_byte(8'h04, 0);
        start = 1'b1;
        send_byte(8'h03, 0);
        start = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h0D, 0);
        send_byte(8'h0C, 0);
        send_byte(8'h0B, 0);
        send_byte(8'h0A, 0);
        rx_valid = 1'b0;
        wait_done("midstart_timeout");
        check("midstart_words", {24'd0, words_loaded}, 2);
        check("midstart_resetpc", {31'd0, resetpc}, 1);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
